key_input_capture: RTL and testbench

- Upstream stage of the two-digit code display. Samples the four code switches and two pushbuttons (LOAD, CLEAR).
- Synchronizes and debounces both buttons.
- Latches the switch code on a LOAD press and holds it, with ready, for the display/encoder path.
- A CLEAR press drives the display into its dash state.

---
 rtl/key_capture_pkg.sv | 15 +
 rtl/key_input_capture_debounce_pulse.sv | 47 ++++
 rtl/key_input_capture.sv | 90 +++++++++
 tb/tb_key_input_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// Shared types and constants for the key capture front end.
// Button levels here are normalized: 1 means pressed, whatever the raw polarity.
package key_capture_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_LOADED  = 2'd1,
      ST_CLEARED = 2'd2
   } capture_state_t;

   localparam int   SYNC_STAGES  = 2;
   localparam logic KEY_PRESSED  = 1'b1;
   localparam logic KEY_RELEASED = 1'b0;

endpackage

// File: rtl/key_input_capture_debounce_pulse.sv
// Per-button synchronizer and debouncer; emits a single-cycle pulse when a
// press has been stable for DEBOUNCE_CYCLES consecutive synchronized samples.
module debounce_pulse
   import key_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic press
);

   localparam int              CW           = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0]   CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic            RAW_RELEASED = KEY_RELEASED ^ KEY_ACTIVE_LOW;

   logic [SYNC_STAGES-1:0] sync;
   logic                   level;
   logic                   stable;
   logic [CW-1:0]          cnt;

   assign level = sync[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync   <= {SYNC_STAGES{RAW_RELEASED}};
         stable <= KEY_RELEASED;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], key};
         press <= 1'b0;
         if (level == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= level;
            cnt    <= '0;
            press  <= (level == KEY_PRESSED);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/key_input_capture.sv
// Switch/button front end for the two-digit code display: latches the code
// on LOAD, forces the display to dashes on CLEAR.
//
//  state      | meaning
//  -----------+--------------------------------------------------
//  ST_EMPTY   | nothing latched since reset, ready=0
//  ST_LOADED  | a..d hold a captured code, ready=1
//  ST_CLEARED | a..d zeroed, disp_reset=1 (display shows dashes)
module key_input_capture
   import key_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sw,
   input  logic       key_load,
   input  logic       key_clr,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       ready,
   output logic       disp_reset
);

   logic [SYNC_STAGES-1:0][3:0] sw_pipe;
   logic                        load_pulse;
   logic                        clr_pulse;
   capture_state_t              state_q;
   capture_state_t              state_d;
   logic [3:0]                  code_q;
   logic [3:0]                  code_d;

   always_ff @(posedge clk) begin
      if (reset) sw_pipe <= '0;
      else       sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], sw};
   end

   debounce_pulse #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_load (
      .clk   (clk),
      .reset (reset),
      .key   (key_load),
      .press (load_pulse)
   );

   debounce_pulse #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_clr (
      .clk   (clk),
      .reset (reset),
      .key   (key_clr),
      .press (clr_pulse)
   );

   // CLEAR has priority so a simultaneous LOAD never sneaks a capture in.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      if (clr_pulse) begin
         state_d = ST_CLEARED;
         code_d  = '0;
      end else if (load_pulse) begin
         state_d = ST_LOADED;
         code_d  = sw_pipe[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         code_q     <= '0;
         ready      <= 1'b0;
         disp_reset <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         ready      <= (state_d == ST_LOADED);
         disp_reset <= (state_d == ST_CLEARED);
      end
   end

   assign {a, b, c, d} = code_q;

endmodule

// File: tb/tb_key_input_capture.sv
// Directed bench for key_input_capture with a 4-cycle debounce window and
// active-low buttons; observed vector is {a,b,c,d,ready,disp_reset}.
module tb_key_input_capture;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] sw = 4'b0000;
   logic       key_load = 1'b1;
   logic       key_clr = 1'b1;
   logic       a, b, c, d, ready, disp_reset;
   logic [5:0] obs;

   int vectors = 0;
   int miscompares = 0;

   assign obs = {a, b, c, d, ready, disp_reset};

   always #5 clk = ~clk;

   key_input_capture #(
      .DEBOUNCE_CYCLES (4),
      .KEY_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .key_load   (key_load),
      .key_clr    (key_clr),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .ready      (ready),
      .disp_reset (disp_reset)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      sw       = 4'($urandom_range(0, 15));
      key_load = 1'($urandom_range(0, 1));
      key_clr  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
         step(1);
         vectors++;
         if (obs !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_cycle%0d got %b expected %b", i, obs, 6'b000000);
         end
         sw       = 4'($urandom_range(0, 15));
         key_load = 1'($urandom_range(0, 1));
         key_clr  = 1'($urandom_range(0, 1));
      end
      reset    = 1'b0;
      key_load = 1'b1;
      key_clr  = 1'b1;
      sw       = 4'b1010;
      step(4);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_idle got %b expected %b", obs, 6'b000000);
      end
   endtask

   task automatic test_load_capture();
      key_load = 1'b0;
      step(6);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL load_early got %b expected %b", obs, 6'b000000);
      end
      step(1);
      vectors++;
      if (obs !== 6'b101010) begin
         miscompares++;
         $display("FAIL load_cycle7 got %b expected %b", obs, 6'b101010);
      end
      step(3);
      vectors++;
      if (obs !== 6'b101010) begin
         miscompares++;
         $display("FAIL load_held got %b expected %b", obs, 6'b101010);
      end
      key_load = 1'b1;
      step(10);
      vectors++;
      if (obs !== 6'b101010) begin
         miscompares++;
         $display("FAIL load_release got %b expected %b", obs, 6'b101010);
      end
   endtask

   task automatic test_bounce();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      sw    = 4'b1111;
      step(4);
      for (int i = 0; i < 8; i++) begin
         key_load = 1'b0;
         step(2);
         key_load = 1'b1;
         step(2);
         vectors++;
         if (obs !== 6'b000000) begin
            miscompares++;
            $display("FAIL bounce_%0d got %b expected %b", i, obs, 6'b000000);
         end
      end
      key_load = 1'b0;
      step(6);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL bounce_hold_early got %b expected %b", obs, 6'b000000);
      end
      step(2);
      vectors++;
      if (obs !== 6'b111110) begin
         miscompares++;
         $display("FAIL bounce_hold_capture got %b expected %b", obs, 6'b111110);
      end
      key_load = 1'b1;
      step(8);
   endtask

   task automatic test_recapture();
      sw = 4'b1010;
      step(3);
      key_load = 1'b0;
      step(8);
      key_load = 1'b1;
      step(8);
      vectors++;
      if (obs !== 6'b101010) begin
         miscompares++;
         $display("FAIL recap_first got %b expected %b", obs, 6'b101010);
      end
      sw = 4'b0101;
      step(10);
      vectors++;
      if (obs !== 6'b101010) begin
         miscompares++;
         $display("FAIL recap_sw_ignored got %b expected %b", obs, 6'b101010);
      end
      key_load = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         vectors++;
         if (i < 7 && obs !== 6'b101010) begin
            miscompares++;
            $display("FAIL recap_hold_%0d got %b expected %b", i, obs, 6'b101010);
         end else if (i == 7 && obs !== 6'b010110) begin
            miscompares++;
            $display("FAIL recap_new got %b expected %b", obs, 6'b010110);
         end
      end
      step(1);
      key_load = 1'b1;
      step(8);
   endtask

   task automatic test_clear();
      key_clr = 1'b0;
      step(6);
      vectors++;
      if (obs !== 6'b010110) begin
         miscompares++;
         $display("FAIL clr_early got %b expected %b", obs, 6'b010110);
      end
      step(1);
      vectors++;
      if (obs !== 6'b000001) begin
         miscompares++;
         $display("FAIL clr_cycle7 got %b expected %b", obs, 6'b000001);
      end
      step(3);
      key_clr = 1'b1;
      step(8);
      key_load = 1'b0;
      key_clr  = 1'b0;
      step(7);
      vectors++;
      if (obs !== 6'b000001) begin
         miscompares++;
         $display("FAIL clr_both got %b expected %b", obs, 6'b000001);
      end
      step(3);
      key_load = 1'b1;
      key_clr  = 1'b1;
      step(8);
      vectors++;
      if (obs !== 6'b000001) begin
         miscompares++;
         $display("FAIL clr_both_after got %b expected %b", obs, 6'b000001);
      end
   endtask

   task automatic test_reset_mid_debounce();
      sw = 4'b0011;
      step(3);
      key_load = 1'b0;
      step(3);
      reset = 1'b1;
      step(1);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL midrst_reset got %b expected %b", obs, 6'b000000);
      end
      reset    = 1'b0;
      key_load = 1'b1;
      step(10);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL midrst_no_capture got %b expected %b", obs, 6'b000000);
      end
      key_load = 1'b0;
      step(6);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL midrst_restart_early got %b expected %b", obs, 6'b000000);
      end
      step(1);
      vectors++;
      if (obs !== 6'b001110) begin
         miscompares++;
         $display("FAIL midrst_restart_capture got %b expected %b", obs, 6'b001110);
      end
      key_load = 1'b1;
      step(8);
      sw = 4'b1100;
      key_load = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(6);
      vectors++;
      if (obs !== 6'b000000) begin
         miscompares++;
         $display("FAIL held_rst_early got %b expected %b", obs, 6'b000000);
      end
      step(1);
      vectors++;
      if (obs !== 6'b110010) begin
         miscompares++;
         $display("FAIL held_rst_capture got %b expected %b", obs, 6'b110010);
      end
      key_load = 1'b1;
      step(8);
   endtask

   initial begin
      test_reset();
      test_load_capture();
      test_bounce();
      test_recapture();
      test_clear();
      test_reset_mid_debounce();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
